reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the single-port register bank. Provides two combinational read ports and one write port, width and depth configurable.
- Register 0 is hardwired to zero.
- Optional write-to-read bypass.
- Per-register pending scoreboard, set at instruction issue and cleared at writeback, used by decode for hazard stalls.
- Built-in sequential clear engine zeroes the array after reset and reports `ready`.
- Sits between decode (read/issue side) and writeback (write side) of the CPU.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = write visible next cycle only.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  pending bit for rs1_addr, after bypass adjustment.
- rs2_busy  out  1  pending bit for rs2_addr, after bypass adjustment.
- wr_en  in  1  write strobe (writeback).
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- issue_en  in  1  instruction issued with destination issue_rd.
- issue_rd  in  AW  destination register of issued instruction.
- ready  out  1  1 = clear complete, block accepts writes and issues.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- State machine:
  - States: CLEAR, RUN.
  - reset=1: state←CLEAR, clr_idx←0, all pending bits←0.
  - CLEAR with reset=0: registers[clr_idx]←0 and clr_idx←clr_idx+1 each cycle. After writing index NREGS-1, state←RUN.
  - `ready` = (state==RUN), registered. `ready` is 0 during reset and rises exactly NREGS cycles after the first clock with reset=0.
  - Reset asserted mid-CLEAR restarts the clear at index 0. Reset asserted in RUN re-enters CLEAR.
- While ready=0:
  - wr_en and issue_en are ignored.
  - rs1_data/rs2_data = 0.
  - rs1_busy/rs2_busy = 0.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - issue_rd=0 never sets a pending bit.
  - Its pending bit reads 0.
- Write (RUN, wr_en=1, wr_addr≠0): registers[wr_addr]←wr_data at the edge; pending[wr_addr]←0.
- Issue (RUN, issue_en=1, issue_rd≠0): pending[issue_rd]←1.
- Same-cycle write and issue to the same nonzero address: data is written, and pending ends at 1 (the new producer wins).
- Read, for each port p:
  - addr=0 → data 0.
  - Else if BYPASS=1, wr_en, RUN and wr_addr==addr → data = wr_data, busy = 0.
  - Else data = registers[addr], busy = pending[addr].
- Both read ports may address the same register, including while it is being written; both return identical results.
- With BYPASS=0, a same-cycle write is not forwarded: read returns the old value and busy stays at the old pending value until the next cycle.
- Reset values:
  - rs*_data = 0, rs*_busy = 0, ready = 0.
  - Array contents are undefined until the clear completes; reads are masked to 0 meanwhile.
- No X propagation: every addressable entry is in range because NREGS = 2^AW.

Test Plan:
- Reset for 3 cycles, then release, NREGS=32 → ready=0 for 32 cycles then 1. Read of any address afterwards = 0, even after prior writes of 0xDEADBEEF before reset.
- RUN, write x5=0x12345678 → same cycle rs1_data=0x12345678 with BYPASS=1 (old value with BYPASS=0). Next cycle both configs read 0x12345678.
- Write x0=0xFFFFFFFF and issue_rd=0 → rs1_addr=0 reads 0, rs1_busy=0.
- issue_rd=7 → next cycle rs2_busy=1 for rs2_addr=7. Then wr x7=0xA5 → bypass cycle busy=0, data 0xA5. Following cycle busy=0.
- Same cycle issue_rd=3 and wr x3=0x11 → next cycle x3=0x11 and busy=1.
- Reset asserted at clear index 10 for 1 cycle → ready rises NREGS cycles after release, not 22. Writes attempted during CLEAR do not land.

Source files
------------

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with pending scoreboard, optional write bypass and post-reset clear engine
module reg_file_mp #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [AW-1:0]     clr_idx;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic              ready_q;

    // The array itself is not reset; the clear engine walks it once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
            pending <= '0;
            ready_q <= 1'b0;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
            clr_idx       <= clr_idx + AW'(1);
            if (clr_idx == AW'(NREGS - 1)) begin
                state   <= RUN;
                ready_q <= 1'b1;
            end
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                regs[wr_addr]    <= wr_data;
                pending[wr_addr] <= 1'b0;
            end
            // Issued after the writeback clear so a new producer wins on collision.
            if (issue_en && (issue_rd != '0)) begin
                pending[issue_rd] <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

    // Returns {busy, data} for one read port.
    function automatic logic [XLEN:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN:0] res;
        res = '0;
        if (ready_q && (addr != '0)) begin
            if (BYPASS && wr_en && (wr_addr == addr)) begin
                res = {1'b0, wr_data};
            end else begin
                res = {pending[addr], regs[addr]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {rs1_busy, rs1_data} = read_port(rs1_addr);
        {rs2_busy, rs2_data} = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed and randomized bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [XLEN-1:0] wr_data;
    logic            wr_en, issue_en;

    logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic            b_ready, n_ready;

    int checks = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    bit              m_ready;
    int              m_cnt;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)) u_bp (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .ready(b_ready)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .ready(n_ready)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit bp);
        if (!m_ready || a == 0) return '0;
        if (bp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit bp);
        if (!m_ready || a == 0) return 1'b0;
        if (bp && wr_en && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".ready_bp"}, {31'b0, b_ready}, {31'b0, m_ready});
        check({tag, ".ready_nb"}, {31'b0, n_ready}, {31'b0, m_ready});
        check({tag, ".rs1_data_bp"}, b_rs1_data, exp_data(rs1_addr, 1'b1));
        check({tag, ".rs2_data_bp"}, b_rs2_data, exp_data(rs2_addr, 1'b1));
        check({tag, ".rs1_busy_bp"}, {31'b0, b_rs1_busy}, {31'b0, exp_busy(rs1_addr, 1'b1)});
        check({tag, ".rs2_busy_bp"}, {31'b0, b_rs2_busy}, {31'b0, exp_busy(rs2_addr, 1'b1)});
        check({tag, ".rs1_data_nb"}, n_rs1_data, exp_data(rs1_addr, 1'b0));
        check({tag, ".rs2_data_nb"}, n_rs2_data, exp_data(rs2_addr, 1'b0));
        check({tag, ".rs1_busy_nb"}, {31'b0, n_rs1_busy}, {31'b0, exp_busy(rs1_addr, 1'b0)});
        check({tag, ".rs2_busy_nb"}, {31'b0, n_rs2_busy}, {31'b0, exp_busy(rs2_addr, 1'b0)});
    endtask

    task automatic model_edge();
        if (reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREGS) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked mid-cycle.
    task automatic tick(input string tag);
        #2;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; issue_en = 0;
        wr_addr = 0; wr_data = 0; issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic randomize_inputs();
        wr_en    = ($urandom_range(0, 1) == 1);
        wr_addr  = AW'($urandom_range(0, NREGS - 1));
        wr_data  = $urandom;
        issue_en = ($urandom_range(0, 2) == 0);
        issue_rd = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
        rs1_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
        rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : AW'($urandom_range(0, NREGS - 1));
    endtask

    initial begin
        idle();
        reset = 1;
        m_ready = 0; m_cnt = 0;
        for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
        @(posedge clk); model_edge(); #1;

        for (int i = 0; i < 3; i++) tick("reset");
        // First clear with junk traffic that must not land.
        reset = 0;
        for (int i = 0; i < NREGS + 2; i++) begin
            randomize_inputs();
            tick("clear1");
        end
        // Fill with DEADBEEF, then reset and verify the clear wipes it.
        idle();
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = 32'hDEADBEEF; rs1_addr = AW'(i);
            tick("fill");
        end
        idle(); reset = 1;
        for (int i = 0; i < 3; i++) tick("reset2");
        reset = 0;
        for (int i = 0; i < NREGS; i++) begin
            rs1_addr = AW'($urandom_range(0, NREGS - 1));
            tick("clear2");
        end
        for (int i = 0; i < NREGS; i++) begin
            rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
            tick("after_clear");
        end

        // Write x5 with same-cycle read, then read next cycle.
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'h12345678; rs1_addr = 5; rs2_addr = 5;
        tick("wr_x5");
        idle(); rs1_addr = 5; rs2_addr = 5;
        tick("rd_x5");
        check("x5_direct", b_rs1_data, 32'h12345678);

        // x0 write and issue are discarded.
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; issue_en = 1; issue_rd = 0;
        tick("wr_x0");
        idle(); rs1_addr = 0; rs2_addr = 0;
        tick("rd_x0");

        // Issue x7, then writeback x7 with bypass.
        idle(); issue_en = 1; issue_rd = 7;
        tick("issue_x7");
        idle(); rs2_addr = 7;
        tick("busy_x7");
        check("x7_busy_direct", {31'b0, b_rs2_busy}, 32'd1);
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hA5; rs1_addr = 7; rs2_addr = 7;
        tick("wb_x7");
        idle(); rs1_addr = 7; rs2_addr = 7;
        tick("after_wb_x7");

        // Same-cycle issue and write of x3: new producer wins.
        idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h11; issue_en = 1; issue_rd = 3;
        tick("wr_issue_x3");
        idle(); rs1_addr = 3; rs2_addr = 3;
        tick("rd_x3");
        check("x3_busy_direct", {31'b0, n_rs1_busy}, 32'd1);

        // Reset during clear at index 10 restarts the clear.
        idle(); reset = 1;
        tick("reset3");
        reset = 0;
        for (int i = 0; i < 10; i++) tick("clear3a");
        reset = 1;
        tick("mid_clear_reset");
        reset = 0;
        for (int i = 0; i < NREGS; i++) begin
            wr_en = 1; wr_addr = AW'($urandom_range(1, NREGS - 1)); wr_data = $urandom;
            issue_en = 1; issue_rd = AW'($urandom_range(1, NREGS - 1));
            rs1_addr = wr_addr; rs2_addr = issue_rd;
            tick("clear3b");
        end
        check("ready_after_restart", {31'b0, b_ready}, 32'd1);
        for (int i = 0; i < NREGS; i++) begin
            idle(); rs1_addr = AW'(i); rs2_addr = AW'(i);
            tick("scan3");
        end

        // Randomized traffic in RUN.
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 299) == 0);
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
